// File: rtl/disk_pkg.sv
// rtl/disk_pkg.sv - shared constants and FSM state type for the disk track streamer
//
// Contents:
//   DEF_TRACK_LEN   default bytes per track (0x1A00)
//   DEF_BYTE_CYCLES default clk_en pulses per disk byte
//   ADDR_W          track buffer address width
//   disk_state_t    byte sequencer states

package disk_pkg;

    localparam int DEF_TRACK_LEN   = 6656;
    localparam int DEF_BYTE_CYCLES = 32;
    localparam int ADDR_W          = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        WRITE = 2'd3
    } disk_state_t;

endpackage

// File: rtl/disk_track_stream_if.sv
// rtl/disk_track_stream_if.sv - track buffer RAM bus between streamer and buffer
//
// Signals:
//   ram_addr  track buffer address (master drives)
//   ram_do    read data, valid one clk after ram_addr (slave drives)
//   ram_di    write data (master drives)
//   ram_we    one-clk write strobe (master drives)

interface disk_track_stream_if;
    import disk_pkg::*;

    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_do;
    logic [7:0]        ram_di;
    logic              ram_we;

    modport master (
        output ram_addr,
        output ram_di,
        output ram_we,
        input  ram_do
    );

    modport slave (
        input  ram_addr,
        input  ram_di,
        input  ram_we,
        output ram_do
    );

endinterface

// File: rtl/disk_byte_timer.sv
// rtl/disk_byte_timer.sv - divides clk_en into one byte_tick per disk byte time
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   clk_en     CPU-rate enable, one count per pulse
//   run        counting allowed (motor on and track mounted); count holds otherwise
//   byte_tick  one-clk pulse, registered, when the count wraps to 0

module disk_byte_timer #(
    parameter int BYTE_CYCLES = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_en,
    input  logic run,
    output logic byte_tick
);

    localparam int CW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTE_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            byte_tick <= 1'b0;
        end else begin
            byte_tick <= 1'b0;
            if (clk_en && run) begin
                if (count == LAST) begin
                    count     <= '0;
                    byte_tick <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/disk_track_stream.sv
// rtl/disk_track_stream.sv - streams a rotating disk track to/from a track buffer RAM
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   clk_en     CPU-rate enable that advances byte timing
//   motor_on   drive motor enabled
//   track_ok   track buffer mounted and not busy
//   wr_mode    write mode selected (sampled only at byte_tick)
//   rd_strobe  one-clk CPU read of the data latch (clears it)
//   wr_load    one-clk CPU load of the write latch
//   wr_data    CPU write byte
//   data_out   read data latch
//   ram        track buffer bus (master side)

module disk_track_stream
    import disk_pkg::*;
#(
    parameter int TRACK_LEN   = DEF_TRACK_LEN,
    parameter int BYTE_CYCLES = DEF_BYTE_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk_en,
    input  logic                    motor_on,
    input  logic                    track_ok,
    input  logic                    wr_mode,
    input  logic                    rd_strobe,
    input  logic                    wr_load,
    input  logic [7:0]              wr_data,
    output logic [7:0]              data_out,
    disk_track_stream_if.master     ram
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TRACK_LEN - 1);

    disk_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        wr_latch;
    logic [7:0]        ram_di_q;
    logic              we_q;
    logic              run;
    logic              byte_tick;

    assign run       = motor_on & track_ok;
    assign next_addr = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

    disk_byte_timer #(
        .BYTE_CYCLES (BYTE_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .run       (run),
        .byte_tick (byte_tick)
    );

    // The strobe is raised on entry to WRITE so it covers exactly the WRITE
    // cycle; gating with run lets a mid-WRITE loss of track or motor kill the
    // pulse in that same cycle instead of one clk late.
    assign ram.ram_we   = we_q & run;
    assign ram.ram_di   = ram_di_q;
    assign ram.ram_addr = addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr     <= '0;
            data_out <= 8'h00;
            ram_di_q <= 8'h00;
            we_q     <= 1'b0;
            wr_latch <= 8'h00;
        end else begin
            we_q <= 1'b0;

            // Loaded here, but ram_di was already captured on WRITE entry,
            // so a load during WRITE lands on the following byte.
            if (wr_load) begin
                wr_latch <= wr_data;
            end

            // A LATCH in the same cycle overrides this clear below.
            if (rd_strobe) begin
                data_out <= 8'h00;
            end

            case (state)
                IDLE: begin
                    if (byte_tick && run) begin
                        if (wr_mode) begin
                            state    <= WRITE;
                            we_q     <= 1'b1;
                            ram_di_q <= wr_latch;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end

                // ram_addr held for one clk so the buffer can present ram_do.
                FETCH: begin
                    state <= run ? LATCH : IDLE;
                end

                LATCH: begin
                    state <= IDLE;
                    if (run) begin
                        data_out <= ram.ram_do;
                        addr     <= next_addr;
                    end
                end

                WRITE: begin
                    state <= IDLE;
                    if (run) begin
                        addr <= next_addr;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disk_track_stream.sv
// tb/tb_disk_track_stream.sv - directed self-checking bench for disk_track_stream

module tb_disk_track_stream;

    logic       clk;
    logic       reset_n;
    logic       clk_en;
    logic       motor_on;
    logic       track_ok;
    logic       wr_mode;
    logic       rd_strobe;
    logic       wr_load;
    logic [7:0] wr_data;
    logic [7:0] data_out;

    int total;
    int bad;
    int en_div;
    int en_cnt;

    logic [7:0] mem [0:8191];

    disk_track_stream_if ram_bus ();

    disk_track_stream #(
        .TRACK_LEN   (6656),
        .BYTE_CYCLES (4)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .motor_on  (motor_on),
        .track_ok  (track_ok),
        .wr_mode   (wr_mode),
        .rd_strobe (rd_strobe),
        .wr_load   (wr_load),
        .wr_data   (wr_data),
        .data_out  (data_out),
        .ram       (ram_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // clk_en: one pulse every en_div clocks, changed at negedges
    always @(negedge clk) begin
        if (en_cnt >= en_div - 1) begin
            clk_en = 1'b1;
            en_cnt = 0;
        end else begin
            clk_en = 1'b0;
            en_cnt = en_cnt + 1;
        end
    end

    // track buffer model: synchronous read, one clk latency
    always @(posedge clk) begin
        if (ram_bus.ram_we) begin
            mem[ram_bus.ram_addr] <= ram_bus.ram_di;
        end
        ram_bus.ram_do <= mem[ram_bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // returns at the negedge where byte_tick is high
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!u_dut.byte_tick && n < 4000);
        check({tag, "_tick"}, {31'd0, u_dut.byte_tick}, 32'd1);
    endtask

    // tick seen -> FETCH -> LATCH -> data_out valid on the third negedge
    task automatic read_byte(input string tag, input logic [7:0] prev, input logic [7:0] exp);
        wait_tick(tag);
        repeat (2) @(negedge clk);
        check({tag, "_hold"}, {24'd0, data_out}, {24'd0, prev});
        @(negedge clk);
        check({tag, "_data"}, {24'd0, data_out}, {24'd0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic over;
        logic [7:0] init_bytes [0:4];

        total = 0;
        bad = 0;
        en_div = 14;
        en_cnt = 0;
        clk_en = 1'b0;
        reset_n = 1'b0;
        motor_on = 1'b0;
        track_ok = 1'b0;
        wr_mode = 1'b0;
        rd_strobe = 1'b0;
        wr_load = 1'b0;
        wr_data = 8'h00;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        init_bytes[0] = 8'hD5;
        init_bytes[1] = 8'hAA;
        init_bytes[2] = 8'h96;
        init_bytes[3] = 8'h3C;
        init_bytes[4] = 8'h77;
        for (int i = 0; i < 5; i++) mem[i] = init_bytes[i];
        mem[6655] = 8'hFF;

        repeat (3) @(negedge clk);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_addr", {19'd0, ram_bus.ram_addr}, 32'd0);
        check("rst_we", {31'd0, ram_bus.ram_we}, 32'd0);
        check("rst_di", {24'd0, ram_bus.ram_di}, 32'h00);
        reset_n = 1'b1;
        motor_on = 1'b1;
        track_ok = 1'b1;

        // three sequential reads
        read_byte("rd0", 8'h00, 8'hD5);
        read_byte("rd1", 8'hD5, 8'hAA);
        read_byte("rd2", 8'hAA, 8'h96);
        check("rd_addr3", {19'd0, ram_bus.ram_addr}, 32'd3);

        // rd_strobe alone clears the latch
        @(negedge clk);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        check("strobe_clear", {24'd0, data_out}, 32'h00);

        // rd_strobe coinciding with LATCH: new byte wins
        wait_tick("stl");
        @(negedge clk);
        @(negedge clk);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        check("strobe_latch", {24'd0, data_out}, 32'h3C);
        check("strobe_addr", {19'd0, ram_bus.ram_addr}, 32'd4);

        // track_ok dropped during FETCH aborts the read
        wait_tick("abt");
        @(negedge clk);
        track_ok = 1'b0;
        repeat (3) @(negedge clk);
        track_ok = 1'b1;
        check("abort_data", {24'd0, data_out}, 32'h3C);
        check("abort_addr", {19'd0, ram_bus.ram_addr}, 32'd4);
        read_byte("reread", 8'h3C, 8'h77);
        check("reread_addr", {19'd0, ram_bus.ram_addr}, 32'd5);

        // writes: FF, D5, then a load during WRITE goes to the next byte
        wr_mode = 1'b1;
        wr_data = 8'hFF;
        wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        wait_tick("wr0");
        check("wr0_we_pre", {31'd0, ram_bus.ram_we}, 32'd0);
        @(negedge clk);
        check("wr0_we", {31'd0, ram_bus.ram_we}, 32'd1);
        check("wr0_addr", {19'd0, ram_bus.ram_addr}, 32'd5);
        check("wr0_di", {24'd0, ram_bus.ram_di}, 32'hFF);
        @(negedge clk);
        check("wr0_we_end", {31'd0, ram_bus.ram_we}, 32'd0);
        check("wr0_addr_nx", {19'd0, ram_bus.ram_addr}, 32'd6);

        wr_data = 8'hD5;
        wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        wait_tick("wr1");
        @(negedge clk);
        wr_data = 8'h5A;
        wr_load = 1'b1;
        check("wr1_we", {31'd0, ram_bus.ram_we}, 32'd1);
        check("wr1_di", {24'd0, ram_bus.ram_di}, 32'hD5);
        @(negedge clk);
        wr_load = 1'b0;
        check("wr1_we_end", {31'd0, ram_bus.ram_we}, 32'd0);

        wait_tick("wr2");
        @(negedge clk);
        check("wr2_di", {24'd0, ram_bus.ram_di}, 32'h5A);
        @(negedge clk);
        check("mem5", {24'd0, mem[5]}, 32'hFF);
        check("mem6", {24'd0, mem[6]}, 32'hD5);
        check("mem7", {24'd0, mem[7]}, 32'h5A);
        check("wr_addr8", {19'd0, ram_bus.ram_addr}, 32'd8);

        // asynchronous reset in the middle of WRITE
        wr_data = 8'h11;
        wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        wait_tick("wrr");
        @(negedge clk);
        check("wrr_we", {31'd0, ram_bus.ram_we}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_we", {31'd0, ram_bus.ram_we}, 32'd0);
        check("arst_addr", {19'd0, ram_bus.ram_addr}, 32'd0);
        check("arst_data", {24'd0, data_out}, 32'h00);
        check("arst_di", {24'd0, ram_bus.ram_di}, 32'h00);
        wr_mode = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // run at one byte per 4 clk up to the last track address
        en_div = 1;
        n = 0;
        over = 1'b0;
        while (ram_bus.ram_addr != 13'd6655 && n < 40000) begin
            @(negedge clk);
            n = n + 1;
            if (ram_bus.ram_addr > 13'd6655) over = 1'b1;
        end
        motor_on = 1'b0;
        check("reach_6655", {19'd0, ram_bus.ram_addr}, 32'd6655);
        check("addr_bound", {31'd0, over}, 32'd0);
        repeat (20) @(negedge clk);
        check("motor_off_addr", {19'd0, ram_bus.ram_addr}, 32'd6655);
        check("motor_off_we", {31'd0, ram_bus.ram_we}, 32'd0);
        motor_on = 1'b1;
        read_byte("wrap0", 8'h00, 8'hFF);
        check("wrap0_addr", {19'd0, ram_bus.ram_addr}, 32'd0);
        read_byte("wrap1", 8'hFF, 8'hD5);
        check("wrap1_addr", {19'd0, ram_bus.ram_addr}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
